// File: rtl/warp_scheduler.sv
// warp_scheduler: per-core controller that time-multiplexes one execution
// pipeline across NUM_WARPS warps. It walks the shared warp_state_t sequence
// (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE), holds one PC per warp,
// rotates warps round-robin per instruction, retires warps on RET and raises
// done once every launched warp has finished.

package warp_scheduler_pkg;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

endpackage

module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter  int NUM_WARPS  = 4,
  parameter  int PC_WIDTH   = 32,
  localparam int WARP_IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_WARPS-1:0]  launch_mask,
  output logic                  fetch_req_valid,
  output logic [PC_WIDTH-1:0]   fetch_req_pc,
  input  logic                  fetch_valid,
  input  logic                  decoded_mem_op,
  input  logic                  decoded_ret,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  lsu_done,
  output logic [WARP_IDX_W-1:0] current_warp,
  output warp_state_t           warp_state,
  output logic [NUM_WARPS-1:0]  warp_enable,
  output logic [NUM_WARPS-1:0]  finished_mask,
  output logic                  done
);

  warp_state_t           state;
  warp_state_t           state_next;

  logic [PC_WIDTH-1:0]   pcs [NUM_WARPS];
  logic [NUM_WARPS-1:0]  launched;

  logic [NUM_WARPS-1:0]  cur_onehot;
  logic [NUM_WARPS-1:0]  finished_upd;
  logic [NUM_WARPS-1:0]  eligible;
  logic [WARP_IDX_W-1:0] first_warp;
  logic                  first_found;
  logic [WARP_IDX_W-1:0] rr_warp;
  logic                  rr_found;
  logic [WARP_IDX_W-1:0] cand;

  // State register; reset returns to IDLE regardless of pending handshakes.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state <= WARP_IDLE;
    else       state <= state_next;
  end

  // Warp selection: lowest launched warp on start, round-robin successor in UPDATE.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves a value held, which would infer a latch.
  always_comb begin
    cur_onehot   = NUM_WARPS'(1) << current_warp;
    finished_upd = finished_mask | (decoded_ret ? cur_onehot : '0);
    eligible     = launched & ~finished_upd;
    first_warp   = '0;
    first_found  = 1'b0;
    rr_warp      = current_warp;
    rr_found     = 1'b0;
    cand         = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!first_found && launch_mask[i]) begin
        first_found = 1'b1;
        first_warp  = WARP_IDX_W'(i);
      end
    end
    // Search current+1 .. current (wrapping); current itself is checked last.
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = WARP_IDX_W'((int'(current_warp) + i) % NUM_WARPS);
      if (!rr_found && eligible[cand]) begin
        rr_found = 1'b1;
        rr_warp  = cand;
      end
    end
  end

  // Next-state logic for the pipeline sequence.
  always_comb begin
    state_next = state;
    case (state)
      WARP_IDLE, WARP_DONE: begin
        if (start) state_next = (launch_mask == '0) ? WARP_DONE : WARP_FETCH;
      end
      WARP_FETCH:   if (fetch_valid) state_next = WARP_DECODE;
      WARP_DECODE:  state_next = WARP_REQUEST;
      WARP_REQUEST: state_next = decoded_mem_op ? WARP_WAIT : WARP_EXECUTE;
      WARP_WAIT:    if (lsu_done) state_next = WARP_EXECUTE;
      WARP_EXECUTE: state_next = WARP_UPDATE;
      WARP_UPDATE:  state_next = rr_found ? WARP_FETCH : WARP_DONE;
      default:      state_next = WARP_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    warp_state      = state;
    fetch_req_valid = (state == WARP_FETCH);
    done            = (state == WARP_DONE);
    warp_enable     = '0;
    if (state inside {WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT,
                      WARP_EXECUTE, WARP_UPDATE}) begin
      warp_enable = cur_onehot;
    end
  end

  assign fetch_req_pc = pcs[current_warp];

  // Per-warp PCs, launch/finish bookkeeping and the current warp pointer.
  // NOTE: the PC array is reset explicitly because its all-zero value is
  // architecturally visible after reset, unlike a plain data memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_warp  <= '0;
      finished_mask <= '0;
      launched      <= '0;
      for (int i = 0; i < NUM_WARPS; i++) pcs[i] <= '0;
    end else begin
      case (state)
        WARP_IDLE, WARP_DONE: begin
          if (start) begin
            launched      <= launch_mask;
            finished_mask <= '0;
            current_warp  <= first_warp;
            for (int i = 0; i < NUM_WARPS; i++) pcs[i] <= '0;
          end
        end
        WARP_UPDATE: begin
          finished_mask <= finished_upd;
          if (!decoded_ret) begin
            pcs[current_warp] <= branch_taken ? branch_target
                                              : pcs[current_warp] + PC_WIDTH'(1);
          end
          if (rr_found) current_warp <= rr_warp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler. A small reference model predicts the
// next fetch (warp, PC) or completion whenever a launch or UPDATE is driven and
// queues it; the prediction is popped when the DUT reaches FETCH or DONE.

module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  localparam int NW  = 4;
  localparam int PCW = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [NW-1:0]   launch_mask;
  logic            fetch_req_valid;
  logic [PCW-1:0]  fetch_req_pc;
  logic            fetch_valid;
  logic            decoded_mem_op;
  logic            decoded_ret;
  logic            branch_taken;
  logic [PCW-1:0]  branch_target;
  logic            lsu_done;
  logic [1:0]      current_warp;
  warp_state_t     warp_state;
  logic [NW-1:0]   warp_enable;
  logic [NW-1:0]   finished_mask;
  logic            done;

  warp_scheduler #(.NUM_WARPS(NW), .PC_WIDTH(PCW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .launch_mask    (launch_mask),
    .fetch_req_valid(fetch_req_valid),
    .fetch_req_pc   (fetch_req_pc),
    .fetch_valid    (fetch_valid),
    .decoded_mem_op (decoded_mem_op),
    .decoded_ret    (decoded_ret),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .lsu_done       (lsu_done),
    .current_warp   (current_warp),
    .warp_state     (warp_state),
    .warp_enable    (warp_enable),
    .finished_mask  (finished_mask),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    int          warp;
    logic [31:0] pc;
  } exp_t;

  exp_t          sb[$];
  int            visit_log[$];
  int            vectors;
  int            miscompares;
  logic [31:0]   m_pc [NW];
  logic [NW-1:0] m_launch;
  logic [NW-1:0] m_fin;
  int            m_cur;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int from);
    for (int k = 0; k < NW; k++) begin
      int w;
      w = (from + k) % NW;
      if (m_launch[w] && !m_fin[w]) return w;
    end
    return -1;
  endfunction

  task automatic push_next(input int from);
    exp_t e;
    int   w;
    w = pick(from);
    e.is_done = (w < 0);
    e.warp    = (w < 0) ? m_cur : w;
    e.pc      = (w < 0) ? 32'h0 : m_pc[w];
    if (w >= 0) m_cur = w;
    sb.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    check("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    if (e.is_done) begin
      check("done_state", warp_state, WARP_DONE);
      check("done_flag", done, 1'b1);
      check("done_fetch_valid", fetch_req_valid, 1'b0);
      check("done_enable", warp_enable, '0);
    end else begin
      visit_log.push_back(e.warp);
      check("fetch_state", warp_state, WARP_FETCH);
      check("fetch_valid_out", fetch_req_valid, 1'b1);
      check("fetch_warp", current_warp, e.warp);
      check("fetch_pc", fetch_req_pc, e.pc);
      check("fetch_enable", warp_enable, 4'(1) << e.warp);
      check("fetch_done_low", done, 1'b0);
    end
  endtask

  task automatic launch(input logic [NW-1:0] mask);
    start       = 1'b1;
    launch_mask = mask;
    tick();
    start       = 1'b0;
    m_launch    = mask;
    m_fin       = '0;
    for (int i = 0; i < NW; i++) m_pc[i] = 32'h0;
    m_cur = 0;
    push_next(0);
    observe();
  endtask

  // One instruction starting in FETCH of the predicted warp.
  task automatic run_instr(input bit mem, input bit ret, input bit br,
                           input logic [31:0] tgt, input int fetch_delay,
                           input int lsu_delay, input bit early_lsu,
                           input bit stray_start);
    logic [NW-1:0] oh;
    oh = 4'(1) << m_cur;
    for (int d = 0; d < fetch_delay; d++) begin
      check("fetch_hold_state", warp_state, WARP_FETCH);
      check("fetch_hold_pc", fetch_req_pc, m_pc[m_cur]);
      if (stray_start) begin
        start       = 1'b1;
        launch_mask = 4'hF;
      end
      tick();
      start = 1'b0;
    end
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    check("decode_state", warp_state, WARP_DECODE);
    check("decode_enable", warp_enable, oh);
    check("decode_fetch_valid", fetch_req_valid, 1'b0);
    decoded_mem_op = mem;
    tick();
    check("request_state", warp_state, WARP_REQUEST);
    if (early_lsu) lsu_done = 1'b1;
    tick();
    lsu_done       = 1'b0;
    decoded_mem_op = 1'b0;
    if (mem) begin
      for (int k = 1; k <= lsu_delay; k++) begin
        check("wait_state", warp_state, WARP_WAIT);
        check("wait_enable", warp_enable, oh);
        check("wait_pc", fetch_req_pc, m_pc[m_cur]);
        if (k == lsu_delay) lsu_done = 1'b1;
        tick();
        lsu_done = 1'b0;
      end
    end
    check("execute_state", warp_state, WARP_EXECUTE);
    tick();
    check("update_state", warp_state, WARP_UPDATE);
    check("update_enable", warp_enable, oh);
    decoded_ret   = ret;
    branch_taken  = br;
    branch_target = tgt;
    tick();
    decoded_ret   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    if (ret)     m_fin[m_cur] = 1'b1;
    else if (br) m_pc[m_cur]  = tgt;
    else         m_pc[m_cur]  = m_pc[m_cur] + 32'd1;
    push_next(m_cur + 1);
    observe();
  endtask

  initial begin
    int exp_visit[6] = '{0, 1, 3, 0, 1, 3};
    int cnt[NW];

    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; launch_mask = '0; fetch_valid = 1'b0;
    decoded_mem_op = 1'b0; decoded_ret = 1'b0; branch_taken = 1'b0;
    branch_target = '0; lsu_done = 1'b0;
    m_cur = 0; m_launch = '0; m_fin = '0;
    tick();
    tick();

    // Reset state
    check("rst_state", warp_state, WARP_IDLE);
    check("rst_warp", current_warp, 2'd0);
    check("rst_fetch_valid", fetch_req_valid, 1'b0);
    check("rst_enable", warp_enable, '0);
    check("rst_finished", finished_mask, '0);
    check("rst_done", done, 1'b0);
    check("rst_pc", fetch_req_pc, '0);
    reset = 1'b0;
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    check("idle_ignores_fetch", warp_state, WARP_IDLE);

    // Single warp: PCs 0,1,2, RET at PC 2
    launch(4'b0001);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 0, 0, 0, 0, 0, 0);
    check("t1_finished", finished_mask, 4'b0001);

    // Round-robin over 0,1,3 with RET on each warp's second instruction
    visit_log.delete();
    for (int i = 0; i < NW; i++) cnt[i] = 0;
    launch(4'b1011);
    for (int n = 0; n < 6; n++) begin
      bit r;
      r = (cnt[m_cur] == 1);
      cnt[m_cur]++;
      run_instr(0, r, 0, 0, 0, 0, 0, 0);
    end
    check("t2_visits", 64'(visit_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < visit_log.size(); i++)
      check("t2_visit_order", 64'(visit_log[i]), 64'(exp_visit[i]));
    check("t2_finished", finished_mask, 4'b1011);

    // Memory op, lsu_done late by 7 WAIT cycles; early pulse in REQUEST ignored
    launch(4'b0001);
    run_instr(1, 0, 0, 0, 0, 7, 1, 0);
    run_instr(0, 1, 0, 0, 0, 0, 0, 0);

    // Branch on warp 1; branch with RET retires without redirect
    launch(4'b0011);
    run_instr(0, 0, 0, 32'h0, 0, 0, 0, 0);
    run_instr(0, 0, 1, 32'h40, 0, 0, 0, 0);
    run_instr(0, 1, 0, 32'h0, 0, 0, 0, 0);
    run_instr(0, 1, 1, 32'h80, 0, 0, 0, 0);
    check("t4_finished", finished_mask, 4'b0011);

    // Reset in the middle of a WAIT
    launch(4'b1111);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 0, 0, 0, 0, 0, 0);
    check("t5_pre_warp", current_warp, 2'd2);
    fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    decoded_mem_op = 1'b1;
    tick();
    tick();
    decoded_mem_op = 1'b0;
    check("t5_wait", warp_state, WARP_WAIT);
    tick();
    check("t5_wait_hold", warp_state, WARP_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_state", warp_state, WARP_IDLE);
    check("t5_rst_enable", warp_enable, '0);
    check("t5_rst_finished", finished_mask, '0);
    check("t5_rst_warp", current_warp, 2'd0);
    check("t5_rst_pc0", fetch_req_pc, '0);
    check("t5_rst_fetch_valid", fetch_req_valid, 1'b0);
    check("t5_rst_done", done, 1'b0);
    lsu_done = 1'b1;
    tick();
    lsu_done = 1'b0;
    check("t5_late_lsu", warp_state, WARP_IDLE);
    sb.delete();

    // Empty launch, then relaunch from DONE; stray start during FETCH ignored
    launch(4'b0000);
    launch(4'b0100);
    run_instr(0, 1, 0, 0, 2, 0, 0, 1);
    check("t6_finished", finished_mask, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
